core_pixel_addr_gen: RTL

//  Parametrised successor of the fixed 8x8 pixel-set address generator. For one tile it sequences three phases:
//  - FILL: AHB/DMA words -> input_mem.
//  - ROTATE: per-pixel byte-lane copy input_mem -> output_mem, with 0/90/180/270 mapping in either direction.
//  - DRAIN: output_mem -> AHB/DMA.

---
 rtl/core_pixel_pkg.sv | 17 +
 rtl/core_pixel_rot_map.sv | 22 ++
 rtl/core_pixel_addr_gen.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/core_pixel_pkg.sv
// core_pixel_pkg: shared state, rotation encodings and helpers for the pixel address generator
package core_pixel_pkg;

   typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_ROT, ST_DRAIN, ST_DONE} state_t;
   typedef enum logic [1:0] {DEG_0, DEG_90, DEG_180, DEG_270} deg_t;
   typedef enum logic {DIR_CW, DIR_CCW} dir_t;

   // A counter-clockwise quarter turn is the complementary clockwise one; 0 and 180 are symmetric
   function automatic logic [1:0] eff_rot(input logic [1:0] deg, input logic dir);
      return (dir == DIR_CCW && deg[0]) ? deg ^ 2'b10 : deg;
   endfunction

   function automatic logic [15:0] clamp_dim(input logic [15:0] v, input logic [15:0] lim);
      return v > lim ? lim : v;
   endfunction

endpackage

// File: rtl/core_pixel_rot_map.sv
// core_pixel_rot_map: maps an input pixel (r,c) to its rotated position and the rotated row width
module core_pixel_rot_map
   import core_pixel_pkg::*;
(
   input  logic [15:0] r,
   input  logic [15:0] c,
   input  logic [15:0] w,
   input  logic [15:0] h,
   input  logic [1:0]  rot,
   output logic [15:0] ro,
   output logic [15:0] co,
   output logic [15:0] wo
);

   // Clockwise coordinate mapping; quarter turns swap the output width to H
   always_comb begin
      ro = rot == DEG_0 ? r : rot == DEG_90 ? c : rot == DEG_180 ? h - 16'd1 - r : w - 16'd1 - c;
      co = rot == DEG_0 ? c : rot == DEG_90 ? h - 16'd1 - r : rot == DEG_180 ? w - 16'd1 - c : r;
      wo = rot[0] ? h : w;
   end

endmodule

// File: rtl/core_pixel_addr_gen.sv
// core_pixel_addr_gen: FILL / ROTATE / DRAIN address sequencer for one (possibly partial) tile
module core_pixel_addr_gen
   import core_pixel_pkg::*;
#(
   parameter int TILE_W    = 8,
   parameter int TILE_H    = 8,
   parameter int BPP       = 3,
   parameter int BUS_BYTES = 4,
   parameter int AW        = 8
) (
   input  logic                      I_HCLK,
   input  logic                      I_HRESET_N,
   input  logic                      I_START,
   input  logic                      I_DMA_READY,
   input  logic [1:0]                I_DEGREES,
   input  logic                      I_DIRECTION,
   input  logic [15:0]               I_WIDTH,
   input  logic [15:0]               I_HEIGHT,
   output logic                      O_BUSY,
   output logic                      O_DONE,
   output logic                      O_FILL_VLD,
   output logic [BUS_BYTES*AW-1:0]   O_FILL_ADDR,
   output logic [BUS_BYTES-1:0]      O_FILL_BE,
   output logic                      O_ROT_VLD,
   output logic [BPP*AW-1:0]         O_ROT_RADDR,
   output logic [BPP*AW-1:0]         O_ROT_WADDR,
   output logic                      O_DRAIN_VLD,
   output logic [BUS_BYTES*AW-1:0]   O_DRAIN_ADDR,
   output logic [BUS_BYTES-1:0]      O_DRAIN_BE,
   output logic [15:0]               O_OUT_W,
   output logic [15:0]               O_OUT_H
);

   state_t                  state;
   logic [15:0]             w, h, w_in, h_in, r, c, r_n, c_n, ro, co, wo;
   logic [1:0]              rot, rot_in;
   logic [31:0]             nb, nb_sel, base, base_n, raddr_base, waddr_base;
   logic                    accept, phase, beat, last_beat, rot_last;
   logic [BUS_BYTES*AW-1:0] bus_addr_n;
   logic [BUS_BYTES-1:0]    bus_be_n;
   logic [BPP*AW-1:0]       raddr_n, waddr_n;

   // Next-cycle beat base and pixel indices; the registered outputs are built from these
   always_comb begin
      w_in      = clamp_dim(I_WIDTH, 16'(TILE_W));
      h_in      = clamp_dim(I_HEIGHT, 16'(TILE_H));
      rot_in    = eff_rot(I_DEGREES, I_DIRECTION);
      accept    = state == ST_IDLE && I_START && w_in != '0 && h_in != '0;
      nb        = 32'(w) * 32'(h) * 32'(BPP);
      nb_sel    = accept ? 32'(w_in) * 32'(h_in) * 32'(BPP) : nb;
      phase     = state == ST_FILL || state == ST_DRAIN;
      beat      = phase && I_DMA_READY;
      last_beat = base + 32'(BUS_BYTES) >= nb;
      rot_last  = state == ST_ROT && r == h - 16'd1 && c == w - 16'd1;
      base_n    = beat ? (last_beat ? '0 : base + 32'(BUS_BYTES)) : (phase ? base : '0);
      r_n       = (state != ST_ROT || rot_last) ? '0 : (c == w - 16'd1 ? r + 16'd1 : r);
      c_n       = (state != ST_ROT || rot_last || c == w - 16'd1) ? '0 : c + 16'd1;
   end

   core_pixel_rot_map u_rot_map (
      .r   (r_n),
      .c   (c_n),
      .w   (w),
      .h   (h),
      .rot (rot),
      .ro  (ro),
      .co  (co),
      .wo  (wo)
   );

   // Per-lane byte addresses, computed wide and truncated to AW only at the lanes
   always_comb begin
      raddr_base = (32'(r_n) * 32'(w) + 32'(c_n)) * 32'(BPP);
      waddr_base = (32'(ro) * 32'(wo) + 32'(co)) * 32'(BPP);
      bus_addr_n = '0;
      bus_be_n   = '0;
      raddr_n    = '0;
      waddr_n    = '0;
      for (int k = 0; k < BUS_BYTES; k++) begin
         bus_addr_n[k*AW +: AW] = AW'(base_n + 32'(k));
         bus_be_n[k]            = base_n + 32'(k) < nb_sel;
      end
      for (int k = 0; k < BPP; k++) begin
         raddr_n[k*AW +: AW] = AW'(raddr_base + 32'(k));
         waddr_n[k*AW +: AW] = AW'(waddr_base + 32'(k));
      end
   end

   // Phase sequencer with registered outputs; each branch drives the phase it is entering
   always_ff @(posedge I_HCLK) begin
      if (!I_HRESET_N) begin
         state        <= ST_IDLE;
         w            <= '0;
         h            <= '0;
         rot          <= '0;
         base         <= '0;
         r            <= '0;
         c            <= '0;
         O_BUSY       <= 1'b0;
         O_DONE       <= 1'b0;
         O_FILL_VLD   <= 1'b0;
         O_FILL_ADDR  <= '0;
         O_FILL_BE    <= '0;
         O_ROT_VLD    <= 1'b0;
         O_ROT_RADDR  <= '0;
         O_ROT_WADDR  <= '0;
         O_DRAIN_VLD  <= 1'b0;
         O_DRAIN_ADDR <= '0;
         O_DRAIN_BE   <= '0;
         O_OUT_W      <= '0;
         O_OUT_H      <= '0;
      end else begin
         base         <= base_n;
         r            <= r_n;
         c            <= c_n;
         O_DONE       <= 1'b0;
         O_FILL_VLD   <= 1'b0;
         O_FILL_ADDR  <= '0;
         O_FILL_BE    <= '0;
         O_ROT_VLD    <= 1'b0;
         O_ROT_RADDR  <= '0;
         O_ROT_WADDR  <= '0;
         O_DRAIN_VLD  <= 1'b0;
         O_DRAIN_ADDR <= '0;
         O_DRAIN_BE   <= '0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state       <= ST_FILL;
                  w           <= w_in;
                  h           <= h_in;
                  rot         <= rot_in;
                  O_BUSY      <= 1'b1;
                  O_OUT_W     <= rot_in[0] ? h_in : w_in;
                  O_OUT_H     <= rot_in[0] ? w_in : h_in;
                  O_FILL_VLD  <= 1'b1;
                  O_FILL_ADDR <= bus_addr_n;
                  O_FILL_BE   <= bus_be_n;
               end
            end
            ST_FILL: begin
               if (beat && last_beat) begin
                  state       <= ST_ROT;
                  O_ROT_VLD   <= 1'b1;
                  O_ROT_RADDR <= raddr_n;
                  O_ROT_WADDR <= waddr_n;
               end else begin
                  O_FILL_VLD  <= 1'b1;
                  O_FILL_ADDR <= bus_addr_n;
                  O_FILL_BE   <= bus_be_n;
               end
            end
            ST_ROT: begin
               if (rot_last) begin
                  state        <= ST_DRAIN;
                  O_DRAIN_VLD  <= 1'b1;
                  O_DRAIN_ADDR <= bus_addr_n;
                  O_DRAIN_BE   <= bus_be_n;
               end else begin
                  O_ROT_VLD   <= 1'b1;
                  O_ROT_RADDR <= raddr_n;
                  O_ROT_WADDR <= waddr_n;
               end
            end
            ST_DRAIN: begin
               if (beat && last_beat) begin
                  state  <= ST_DONE;
                  O_DONE <= 1'b1;
               end else begin
                  O_DRAIN_VLD  <= 1'b1;
                  O_DRAIN_ADDR <= bus_addr_n;
                  O_DRAIN_BE   <= bus_be_n;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               O_BUSY  <= 1'b0;
               O_OUT_W <= '0;
               O_OUT_H <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
